// File: rtl/flash_pkg.sv
// Shared constants and FSM state type for the Pass-Keeper flash store.
package flash_pkg;

    localparam int FLASH_ADDR_W = 4;
    localparam int FLASH_DATA_W = 256;
    // The top address is reserved, so one slot is never usable.
    localparam int MAX_RECORDS  = (1 << FLASH_ADDR_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        PROG,
        ACK,
        ERASE
    } state_t;

endpackage

// File: rtl/flash_array.sv
// Record storage with a valid bitmap; invalid entries always read as zero.
module flash_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            rdata <= '0;
        end else begin
            rdata <= valid[raddr] ? mem[raddr] : '0;
            if (we) begin
                valid[waddr] <= 1'b1;
            end else if (clr) begin
                valid[waddr] <= 1'b0;
            end
        end
    end

    // Contents are deliberately not reset; the valid bitmap masks stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end else if (clr) begin
            mem[waddr] <= '0;
        end
    end

endmodule

// File: rtl/flash_store_responder.sv
// Flash-side responder: append/overwrite records with emulated program latency and an erase walk.
module flash_store_responder
    import flash_pkg::*;
#(
    parameter int ADDR_W      = FLASH_ADDR_W,
    parameter int DATA_W      = FLASH_DATA_W,
    parameter int PROG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash_write,
    input  logic [ADDR_W-1:0] add_flash,
    input  logic [DATA_W-1:0] write_data_flash,
    input  logic              erase,
    output logic [DATA_W-1:0] data_flash,
    output logic [ADDR_W-1:0] max_address,
    output logic              busy,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              full
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    state_t            state;
    state_t            state_next;
    logic [3:0]        timer;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] prog_addr;
    logic [ADDR_W-1:0] erase_idx;
    logic [DATA_W-1:0] prog_data;
    logic              req_ok;
    logic              req_bad;
    logic              commit;

    always_comb begin
        state_next = state;
        req_ok     = 1'b0;
        req_bad    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                // Erase wins over a simultaneous write, which is then reported as rejected.
                if (erase) begin
                    state_next = ERASE;
                    req_bad    = flash_write;
                end else if (flash_write) begin
                    if (add_flash <= count && add_flash != TOP_ADDR) begin
                        state_next = PROG;
                        req_ok     = 1'b1;
                    end else begin
                        req_bad = 1'b1;
                    end
                end
            end
            PROG: begin
                if (timer == 4'd0) begin
                    commit     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:   state_next = IDLE;
            ERASE: begin
                if (erase_idx == TOP_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            count       <= '0;
            prog_addr   <= '0;
            prog_data   <= '0;
            erase_idx   <= '0;
            wr_err      <= 1'b0;
            max_address <= '0;
            full        <= 1'b0;
        end else begin
            state       <= state_next;
            wr_err      <= req_bad;
            max_address <= count;
            full        <= (count == TOP_ADDR);
            if (req_ok) begin
                prog_addr <= add_flash;
                prog_data <= write_data_flash;
                timer     <= 4'(PROG_CYCLES - 1);
            end
            if (state == PROG && timer != 4'd0) begin
                timer <= timer - 4'd1;
            end
            if (commit && prog_addr == count) begin
                count <= count + ADDR_W'(1);
            end
            if (state == IDLE && erase) begin
                count     <= '0;
                erase_idx <= '0;
            end
            if (state == ERASE) begin
                erase_idx <= erase_idx + ADDR_W'(1);
            end
        end
    end

    assign busy   = (state == PROG) || (state == ERASE);
    assign wr_ack = (state == ACK);

    flash_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (commit),
        .clr  (state == ERASE),
        .waddr((state == ERASE) ? erase_idx : prog_addr),
        .wdata(prog_data),
        .raddr(add_flash),
        .rdata(data_flash)
    );

endmodule
